// File: rtl/blob_array.sv
// blob_array -- multi-channel sprite window engine.
//
// Holds NUM_SPRITES rectangular windows. On every pixel strobe (clk25en) the
// current raster position is tested against every window; each sprite keeps
// its own linear RAM address counter that advances once per pixel it covers.
// The highest-layer hitting sprite (lowest index on a tie) is forwarded to the
// pixel arbiter as a registered one-clk request carrying its address, layer
// and index. Sticky per-frame collision flags mark sprites that overlapped.
//
// Handshake: request is a single-cycle valid with no ready. The arbiter must
// take address_out/layer_out/sprite_id in the clk cycle request is high.
// Those three outputs hold their last value while request is low.
//
// Ports:
//   clk, resetn        system clock, asynchronous active-low reset
//   clk25en            one-clk pixel strobe
//   sprite_enable      per-sprite show enable
//   x1/y1/x2/y2_pos    packed inclusive window corners, sprite i at [i*POS_W +: POS_W]
//   address_in         packed per-sprite base address
//   layer_in           packed per-sprite layer, higher value wins
//   curr_x/y_pos       current raster position
//   blank              1 = outside the visible area
//   request            one-clk pulse, pixel needed from the arbiter
//   address_out        address for the winning sprite
//   layer_out          layer of the winning sprite
//   sprite_id          index of the winning sprite
//   hit_vec            hit flags of the last strobe
//   collision          sticky: sprite overlapped another this frame
module blob_array #(
  parameter int NUM_SPRITES = 4,
  parameter int POS_W       = 10,
  parameter int ADDR_W      = 16,
  parameter int LAYER_W     = 2,
  localparam int SID_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         clk25en,
  input  logic [NUM_SPRITES-1:0]       sprite_enable,
  input  logic [NUM_SPRITES*POS_W-1:0] x1_pos,
  input  logic [NUM_SPRITES*POS_W-1:0] y1_pos,
  input  logic [NUM_SPRITES*POS_W-1:0] x2_pos,
  input  logic [NUM_SPRITES*POS_W-1:0] y2_pos,
  input  logic [NUM_SPRITES*ADDR_W-1:0] address_in,
  input  logic [NUM_SPRITES*LAYER_W-1:0] layer_in,
  input  logic [POS_W-1:0]             curr_x_pos,
  input  logic [POS_W-1:0]             curr_y_pos,
  input  logic                         blank,
  output logic                         request,
  output logic [ADDR_W-1:0]            address_out,
  output logic [LAYER_W-1:0]           layer_out,
  output logic [SID_W-1:0]             sprite_id,
  output logic [NUM_SPRITES-1:0]       hit_vec,
  output logic [NUM_SPRITES-1:0]       collision
);

  logic                   request_q;
  logic [ADDR_W-1:0]      address_q;
  logic [LAYER_W-1:0]     layer_q;
  logic [SID_W-1:0]       sprite_id_q;
  logic [NUM_SPRITES-1:0] hit_q;
  logic [NUM_SPRITES-1:0] collision_q;
  logic [NUM_SPRITES-1:0] collision_d;
  logic [ADDR_W-1:0]      cnt_q [NUM_SPRITES];
  logic [ADDR_W-1:0]      cnt_d [NUM_SPRITES];
  logic [ADDR_W-1:0]      ea    [NUM_SPRITES];

  logic [NUM_SPRITES-1:0] hit;
  logic                   fs;
  logic                   multi_hit;

  logic                   win_found;
  logic [SID_W-1:0]       win_id;
  logic [LAYER_W-1:0]     win_layer;
  logic [ADDR_W-1:0]      win_addr;

  // Frame start is only meaningful on a strobe; outside a strobe nothing
  // that depends on it is registered anyway.
  assign fs = clk25en && (curr_x_pos == '0) && (curr_y_pos == '0);

  // Window test, effective address and counter next-state per sprite.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      hit[i] = sprite_enable[i] && !blank &&
               (x1_pos[i*POS_W +: POS_W] <= curr_x_pos) &&
               (curr_x_pos <= x2_pos[i*POS_W +: POS_W]) &&
               (y1_pos[i*POS_W +: POS_W] <= curr_y_pos) &&
               (curr_y_pos <= y2_pos[i*POS_W +: POS_W]);
      ea[i] = fs ? address_in[i*ADDR_W +: ADDR_W] : cnt_q[i];
      // A disabled sprite parks on its base so re-enabling restarts the image.
      if (!sprite_enable[i]) begin
        cnt_d[i] = address_in[i*ADDR_W +: ADDR_W];
      end else begin
        cnt_d[i] = ea[i] + ADDR_W'(hit[i]);
      end
    end
  end

  // Winner selection: strict greater-than keeps the lowest index on a tie.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_layer = '0;
    win_addr  = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (hit[i] && (!win_found || (layer_in[i*LAYER_W +: LAYER_W] > win_layer))) begin
        win_found = 1'b1;
        win_id    = SID_W'(i);
        win_layer = layer_in[i*LAYER_W +: LAYER_W];
        win_addr  = ea[i];
      end
    end
  end

  // Two or more bits set <=> clearing the lowest set bit leaves something.
  assign multi_hit = |(hit & (hit - NUM_SPRITES'(1)));

  // At frame start older flags are dropped, but an overlap on the (0,0)
  // pixel itself still counts for the new frame.
  assign collision_d = (fs ? '0 : collision_q) | (multi_hit ? hit : '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      request_q   <= 1'b0;
      address_q   <= '0;
      layer_q     <= '0;
      sprite_id_q <= '0;
      hit_q       <= '0;
      collision_q <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      request_q <= 1'b0;
      if (clk25en) begin
        request_q <= win_found;
        if (win_found) begin
          address_q   <= win_addr;
          layer_q     <= win_layer;
          sprite_id_q <= win_id;
        end
        hit_q       <= hit;
        collision_q <= collision_d;
        for (int i = 0; i < NUM_SPRITES; i++) begin
          cnt_q[i] <= cnt_d[i];
        end
      end
    end
  end

  assign request     = request_q;
  assign address_out = address_q;
  assign layer_out   = layer_q;
  assign sprite_id   = sprite_id_q;
  assign hit_vec     = hit_q;
  assign collision   = collision_q;

endmodule

// File: tb/tb_blob_array.sv
// Testbench for blob_array: directed raster frames on a 16-pixel-wide screen,
// a pixel-level reference model and a per-cycle output compare.
module tb_blob_array;

  localparam int N  = 4;
  localparam int PW = 10;
  localparam int AW = 16;
  localparam int LW = 2;
  localparam int SW = 2;
  localparam int W  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          clk25en = 1'b0;
  logic [N-1:0]  en = '0;
  logic [PW-1:0] sx1 [N];
  logic [PW-1:0] sy1 [N];
  logic [PW-1:0] sx2 [N];
  logic [PW-1:0] sy2 [N];
  logic [AW-1:0] sbase [N];
  logic [LW-1:0] slay [N];
  logic [PW-1:0] cur_x = '0;
  logic [PW-1:0] cur_y = '0;
  logic          blank = 1'b0;

  logic [N*PW-1:0] x1_pos, y1_pos, x2_pos, y2_pos;
  logic [N*AW-1:0] address_in;
  logic [N*LW-1:0] layer_in;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign x1_pos[g*PW +: PW]     = sx1[g];
    assign y1_pos[g*PW +: PW]     = sy1[g];
    assign x2_pos[g*PW +: PW]     = sx2[g];
    assign y2_pos[g*PW +: PW]     = sy2[g];
    assign address_in[g*AW +: AW] = sbase[g];
    assign layer_in[g*LW +: LW]   = slay[g];
  end

  logic          request;
  logic [AW-1:0] address_out;
  logic [LW-1:0] layer_out;
  logic [SW-1:0] sprite_id;
  logic [N-1:0]  hit_vec;
  logic [N-1:0]  collision;

  blob_array #(.NUM_SPRITES(N), .POS_W(PW), .ADDR_W(AW), .LAYER_W(LW)) dut (
    .clk(clk), .resetn(resetn), .clk25en(clk25en), .sprite_enable(en),
    .x1_pos(x1_pos), .y1_pos(y1_pos), .x2_pos(x2_pos), .y2_pos(y2_pos),
    .address_in(address_in), .layer_in(layer_in),
    .curr_x_pos(cur_x), .curr_y_pos(cur_y), .blank(blank),
    .request(request), .address_out(address_out), .layer_out(layer_out),
    .sprite_id(sprite_id), .hit_vec(hit_vec), .collision(collision)
  );

  // ---------------- scoreboard / model ----------------
  int errors = 0;
  int checks = 0;
  int req_seen = 0;
  int cap [0:255];

  logic          exp_request = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [LW-1:0] exp_layer = '0;
  logic [SW-1:0] exp_id = '0;
  logic [N-1:0]  exp_hit = '0;
  logic [N-1:0]  exp_coll = '0;
  logic [AW-1:0] m_cnt [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_request = 1'b0; exp_addr = '0; exp_layer = '0; exp_id = '0;
    exp_hit = '0; exp_coll = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = '0;
  endtask

  // What the next strobe edge must produce, from the pixel rules directly.
  task automatic model_strobe();
    logic [N-1:0] h;
    int nh, maxl, best;
    logic f;
    f = (cur_x == 0) && (cur_y == 0);
    h = '0; nh = 0;
    for (int i = 0; i < N; i++) begin
      if (en[i] && !blank && sx1[i] <= cur_x && cur_x <= sx2[i] &&
          sy1[i] <= cur_y && cur_y <= sy2[i]) begin
        h[i] = 1'b1; nh++;
      end
    end
    maxl = -1;
    for (int i = 0; i < N; i++) if (h[i] && int'(slay[i]) > maxl) maxl = int'(slay[i]);
    best = -1;
    for (int i = N - 1; i >= 0; i--) if (h[i] && int'(slay[i]) == maxl) best = i;
    exp_request = (nh > 0);
    if (nh > 0) begin
      exp_addr  = f ? sbase[best] : m_cnt[best];
      exp_layer = slay[best];
      exp_id    = SW'(best);
    end
    exp_hit = h;
    if (f) exp_coll = '0;
    if (nh >= 2) exp_coll = exp_coll | h;
    for (int i = 0; i < N; i++) begin
      if (!en[i]) m_cnt[i] = sbase[i];
      else m_cnt[i] = (f ? sbase[i] : m_cnt[i]) + AW'(h[i]);
    end
  endtask

  // Per-cycle compare, sampled 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    chk("request", 32'(request), 32'(exp_request));
    chk("address_out", 32'(address_out), 32'(exp_addr));
    chk("layer_out", 32'(layer_out), 32'(exp_layer));
    chk("sprite_id", 32'(sprite_id), 32'(exp_id));
    chk("hit_vec", 32'(hit_vec), 32'(exp_hit));
    chk("collision", 32'(collision), 32'(exp_coll));
    if (request === 1'b1) begin
      req_seen++;
      cap[int'(cur_y) * W + int'(cur_x)] = int'(address_out);
    end
  end

  // ---------------- driver tasks ----------------
  // One pixel: three idle clks, then one strobe clk; returns 2 units after
  // the strobe edge with the strobe already dropped.
  task automatic px(input int x, input int y, input logic bl);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin cur_x = PW'(x); cur_y = PW'(y); blank = bl; end
      clk25en = (k == 3);
      if (k == 3) model_strobe();
      else exp_request = 1'b0;
    end
    @(posedge clk); #2;
    clk25en = 1'b0;
    exp_request = 1'b0;
  endtask

  task automatic clear_cap();
    req_seen = 0;
    for (int i = 0; i < 256; i++) cap[i] = -1;
  endtask

  task automatic frame(input int h, input int blo, input int bhi);
    clear_cap();
    for (int y = 0; y < h; y++)
      for (int x = 0; x < W; x++)
        px(x, y, (y >= blo && y <= bhi));
  endtask

  task automatic set_win(input int i, input int x1, input int y1, input int x2,
                         input int y2, input int base, input int lay);
    sx1[i] = PW'(x1); sy1[i] = PW'(y1); sx2[i] = PW'(x2); sy2[i] = PW'(y2);
    sbase[i] = AW'(base); slay[i] = LW'(lay);
  endtask

  function automatic int at(input int x, input int y);
    return y * W + x;
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    for (int i = 0; i < N; i++) set_win(i, 0, 0, 0, 0, 0, 0);
    model_reset();
    clear_cap();
    repeat (3) @(negedge clk);
    chk("reset_request", 32'(request), 0);
    chk("reset_address", 32'(address_out), 0);
    chk("reset_collision", 32'(collision), 0);
    resetn = 1'b1;

    // Single sprite, two frames.
    set_win(0, 3, 5, 6, 7, 1, 3);
    en = 4'b0001;
    for (int f = 0; f < 2; f++) begin
      frame(10, -1, -1);
      chk("t1_req_count", 32'(req_seen), 12);
      chk("t1_addr_3_5", cap[at(3, 5)], 1);
      chk("t1_addr_6_5", cap[at(6, 5)], 4);
      chk("t1_addr_3_6", cap[at(3, 6)], 5);
      chk("t1_addr_6_7", cap[at(6, 7)], 12);
    end

    // Priority and collision.
    set_win(0, 8, 10, 12, 10, 100, 1);
    set_win(1, 10, 10, 10, 10, 200, 3);
    en = 4'b0011;
    px(0, 0, 1'b0);
    px(8, 10, 1'b0);
    px(9, 10, 1'b0);
    px(10, 10, 1'b0);
    chk("pri_id", 32'(sprite_id), 1);
    chk("pri_layer", 32'(layer_out), 3);
    chk("pri_addr", 32'(address_out), 200);
    chk("pri_hit_vec", 32'(hit_vec), 3);
    chk("pri_collision", 32'(collision), 3);
    px(11, 10, 1'b0);
    chk("pri_s0_advanced", 32'(address_out), 103);
    chk("pri_s0_id", 32'(sprite_id), 0);
    px(12, 10, 1'b0);
    chk("coll_sticky", 32'(collision), 3);
    px(0, 0, 1'b0);
    chk("coll_cleared_fs", 32'(collision), 0);
    slay[1] = 2'd1;
    px(10, 10, 1'b0);
    chk("tie_id", 32'(sprite_id), 0);
    chk("tie_addr", 32'(address_out), 100);
    px(11, 10, 1'b0);
    chk("tie_s0_advanced", 32'(address_out), 101);

    // Degenerate window.
    en = 4'b0001;
    set_win(0, 6, 5, 3, 7, 1, 3);
    frame(10, -1, -1);
    chk("degenerate_reqs", 32'(req_seen), 0);

    // Blank over the window, then only the first window row blanked.
    set_win(0, 3, 5, 6, 7, 1, 3);
    frame(10, 5, 7);
    chk("blank_reqs", 32'(req_seen), 0);
    frame(10, 5, 5);
    chk("blank_row_reqs", 32'(req_seen), 8);
    chk("blank_cnt_held", cap[at(3, 6)], 1);

    // Window containing (0,0).
    set_win(0, 0, 0, 2, 0, 50, 0);
    px(0, 0, 1'b0);
    chk("origin_req", 32'(request), 1);
    chk("origin_addr", 32'(address_out), 50);
    px(1, 0, 1'b0);
    chk("origin_addr2", 32'(address_out), 51);

    // Disable at (4,6), re-enable at (3,7).
    set_win(0, 3, 5, 6, 7, 1, 3);
    clear_cap();
    for (int y = 0; y < 10; y++)
      for (int x = 0; x < W; x++) begin
        en[0] = !(at(x, y) >= at(4, 6) && at(x, y) < at(3, 7));
        px(x, y, 1'b0);
      end
    en[0] = 1'b1;
    chk("dis_before", cap[at(3, 6)], 5);
    chk("dis_no_req", cap[at(4, 6)], -1);
    chk("reen_base", cap[at(3, 7)], 1);
    chk("reen_next", cap[at(4, 7)], 2);

    // Async reset mid-window.
    px(0, 0, 1'b0);
    px(3, 5, 1'b0);
    px(4, 5, 1'b0);
    chk("pre_reset_req", 32'(request), 1);
    chk("pre_reset_addr", 32'(address_out), 2);
    #1;
    resetn = 1'b0;
    model_reset();
    #1;
    chk("async_req", 32'(request), 0);
    chk("async_addr", 32'(address_out), 0);
    chk("async_layer", 32'(layer_out), 0);
    chk("async_hit_vec", 32'(hit_vec), 0);
    @(negedge clk);
    resetn = 1'b1;
    frame(10, -1, -1);
    chk("post_reset_reqs", 32'(req_seen), 12);
    chk("post_reset_first", cap[at(3, 5)], 1);
    chk("post_reset_last", cap[at(6, 7)], 12);

    // Address wrap.
    sbase[0] = 16'hFFFF;
    frame(10, -1, -1);
    chk("wrap_first", cap[at(3, 5)], 32'hFFFF);
    chk("wrap_second", cap[at(4, 5)], 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/blob_array.md
# blob_array

Multi-channel sprite ("blob") window engine; parametrised successor to the single-sprite blob. Holds NUM_SPRITES independent rectangular windows. On every 25 MHz pixel strobe it tests the current raster position against all windows and keeps a per-sprite linear RAM address counter. It issues one registered request to the pixel arbiter carrying the winning sprite's address, layer and index, and raises sticky per-frame overlap flags.

## Interface
Parameters:
- NUM_SPRITES, 4, number of sprite channels (1..16)
- POS_W, 10, width of screen coordinates
- ADDR_W, 16, width of sprite RAM address
- LAYER_W, 2, width of layer/priority field

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- clk25en  in  1  one-clk pixel strobe (1 in 4 clk)
- sprite_enable  in  NUM_SPRITES  per-sprite show enable
- x1_pos, y1_pos, x2_pos, y2_pos  in  NUM_SPRITES*POS_W each  packed inclusive window corners; sprite i at bits [i*POS_W +: POS_W]
- address_in  in  NUM_SPRITES*ADDR_W  packed per-sprite base address
- layer_in  in  NUM_SPRITES*LAYER_W  packed per-sprite layer; higher wins
- curr_x_pos, curr_y_pos  in  POS_W  current raster position
- blank  in  1  1 = outside visible area
- request  out  1  one-clk pulse, pixel needed from arbiter
- address_out  out  ADDR_W  address for winning sprite
- layer_out  out  LAYER_W  layer of winning sprite
- sprite_id  out  clog2(NUM_SPRITES) (min 1)  index of winning sprite
- hit_vec  out  NUM_SPRITES  registered hit flags of last strobe
- collision  out  NUM_SPRITES  sticky: sprite overlapped another this frame

## Operation
- Hit(i) = sprite_enable[i] & ~blank & x1≤curr_x≤x2 & y1≤curr_y≤y2 (unsigned, inclusive). x1>x2 or y1>y2 → never hits.
- Frame start (fs) = clk25en & curr_x_pos==0 & curr_y_pos==0.
- Per-sprite counter cnt[i]; effective address ea[i] = fs ? address_in[i] : cnt[i].
- On clk edge with clk25en=1:
  - cnt[i] ← ea[i] + Hit(i), modulo 2^ADDR_W. This holds for every hitting sprite, winner or not, so each sprite reads base + row*width + col of its own window.
  - Winner = hitting sprite with highest layer_in; tie → lowest index.
  - Any hit: request←1; address_out←ea[winner]; layer_out, sprite_id←winner's values.
  - No hit: request←0; address_out, layer_out, sprite_id hold.
  - hit_vec←Hit vector.
  - Popcount(Hit) ≥ 2: collision[i] set for every hitting i.
  - fs: collision ← hits of that pixel only. Older flags clear; sets from the (0,0) pixel apply.
- Edges with clk25en=0: request←0; all other state holds.
- sprite_enable[i]=0 → cnt[i] loaded with address_in[i] each strobe. Re-enabling mid-frame starts at the base address.
- Window/base/layer changes mid-frame take effect at the next strobe. cnt is not reloaded until fs or disable.
- blank=1: no hits, no increment, request 0. fs reload still applies.

## Timing
- Reset (resetn=0, async): request=0, address_out=0, layer_out=0, sprite_id=0, hit_vec=0, collision=0, all cnt=0. Release is synchronous to clk.
- Latency: outputs registered at the strobe edge and valid the following clk cycle. request is high exactly one clk per hitting pixel, never two consecutive clks.
- Reset asserted mid-frame: all state cleared. First correct addresses from the next fs, or immediately for a sprite toggled off and on.
- Combinational depth: NUM_SPRITES comparators plus a priority tree. Must close at the system clk with NUM_SPRITES=16.

## Test plan
- Single sprite: x1=3,y1=5,x2=6,y2=7, base 1, layer 3, 640-wide line, 30-line frame. Expect exactly 12 requests per frame: (3,5)→1, (6,5)→4, (3,6)→5, (6,7)→12. Frame 2 restarts at 1.
- Priority: sprite0 layer 1 and sprite1 layer 3, both covering (10,10) → sprite_id=1, layer_out=3. With equal layers → sprite_id=0. sprite0's counter still advances on the shared pixel.
- Collision: overlap at one pixel sets collision=2'b11 and hit_vec=2'b11. Flags persist to fs, then clear if (0,0) is not overlapped.
- Degenerate and blank: x1=6,x2=3 → zero requests. blank=1 over the window → zero requests and cnt unchanged. A window containing (0,0) → first address = base.
- Disable/enable mid-window: drop sprite_enable at (4,6), restore at (3,7) → next address = base, not continuation.
- Async reset: resetn low mid-window between clk edges → outputs go to 0 immediately. After release plus the next fs, the sequence matches test 1. Base 16'hFFFF wraps to 16'h0000 on the second pixel.
